// File: rtl/sign_narrower_pkg.sv
// Shared widths, saturation constants and FIFO entry type for the 32->16 signed narrower.
package sign_narrower_pkg;
   localparam int W_IN  = 32;
   localparam int W_OUT = 16;
   localparam int DEPTH = 2;
   localparam logic [W_OUT-1:0] SAT_POS = 16'h7FFF;
   localparam logic [W_OUT-1:0] SAT_NEG = 16'h8000;

   typedef struct packed {
      logic [W_OUT-1:0] data;
      logic             ovf;
   } entry_t;

   // Representable iff the top 17 bits are all copies of the sign bit.
   function automatic entry_t narrow(input logic [W_IN-1:0] x, input logic sat);
      entry_t e;
      e.ovf  = (|x[W_IN-1:W_OUT-1]) & ~(&x[W_IN-1:W_OUT-1]);
      e.data = x[W_OUT-1:0];
      if (e.ovf && sat) e.data = x[W_IN-1] ? SAT_NEG : SAT_POS;
      return e;
   endfunction
endpackage

// File: rtl/sign_narrower_if.sv
// Input/output valid-ready handshake bundle of the sign narrower.
interface sign_narrower_if;
   import sign_narrower_pkg::*;
   logic             in_valid;
   logic             in_ready;
   logic [W_IN-1:0]  in_data;
   logic             sat_en;
   logic             out_valid;
   logic             out_ready;
   logic [W_OUT-1:0] out_data;
   logic             out_ovf;

   modport slave (
      input  in_valid, in_data, sat_en, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );
   modport master (
      output in_valid, in_data, sat_en, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );
endinterface

// File: rtl/sign_narrower_fifo.sv
// Two-entry FIFO of narrowed results; 1-bit pointers, occupancy counter.
module narrow_fifo2
   import sign_narrower_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  entry_t wdata,
   output entry_t rdata,
   output logic   full,
   output logic   empty
);
   entry_t     mem [DEPTH];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;

   assign full  = (count == 2'(DEPTH));
   assign empty = (count == 2'd0);
   assign rdata = mem[rd_ptr];

   // Memory is cleared on reset so the output bus reads zero while held in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sign_narrower.sv
// Narrows 32-bit signed words to 16 bits (wrap or saturate), buffers them and counts overflows.
module sign_narrower
   import sign_narrower_pkg::*;
#(
   parameter int DEPTH = sign_narrower_pkg::DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   sign_narrower_if.slave   bus,
   input  logic             cnt_clr,
   output logic [W_OUT-1:0] ovf_cnt
);
   entry_t nw;
   entry_t head;
   logic   full;
   logic   empty;
   logic   rdy_q;
   logic   push;
   logic   pop;

   // rdy_q keeps in_ready low during reset and the cycle it is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   assign bus.in_ready  = rdy_q & ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = head.data;
   assign bus.out_ovf   = head.ovf;

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;
   assign nw   = narrow(bus.in_data, bus.sat_en);

   narrow_fifo2 #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (nw),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // Clear has priority; count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              ovf_cnt <= '0;
      else if (cnt_clr)                        ovf_cnt <= '0;
      else if (push && nw.ovf && ~&ovf_cnt)    ovf_cnt <= ovf_cnt + 16'd1;
   end
endmodule

// File: tb/tb_sign_narrower.sv
// Randomized scoreboard bench for sign_narrower with an arithmetic reference model.
module tb_sign_narrower;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [15:0] ovf_cnt;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [16:0] q[$];
   int          cnt_m = 0;
   bit          rdy_m = 0;
   bit          rand_on = 0;

   sign_narrower_if bus ();

   sign_narrower dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .cnt_clr (cnt_clr),
      .ovf_cnt (ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [16:0] ref_narrow(input logic [31:0] x, input bit sat);
      int          v;
      bit          o;
      logic [15:0] d;
      v = $signed(x);
      o = (v > 32767) || (v < -32768);
      d = x[15:0];
      if (o && sat) d = (v > 0) ? 16'h7FFF : 16'h8000;
      return {d, o};
   endfunction

   // Monitor: compare presented state against the model, then advance the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data", bus.out_data, 0);
         chk("rst_ovf_cnt", ovf_cnt, 0);
         q.delete();
         cnt_m = 0;
         rdy_m = 0;
      end else begin
         chk("in_ready", bus.in_ready, (rdy_m && q.size() < 2) ? 1 : 0);
         chk("out_valid", bus.out_valid, (q.size() != 0) ? 1 : 0);
         chk("ovf_cnt", ovf_cnt, cnt_m);
         if (q.size() != 0) begin
            chk("out_word", {bus.out_data, bus.out_ovf}, q[0]);
            if (bus.out_ready) void'(q.pop_front());
         end
         if (bus.in_valid && bus.in_ready) begin
            logic [16:0] e;
            e = ref_narrow(bus.in_data, bus.sat_en);
            q.push_back(e);
            if (!cnt_clr && e[0] && cnt_m < 65535) cnt_m++;
         end
         if (cnt_clr) cnt_m = 0;
         rdy_m = 1;
      end
   end

   task automatic push(input logic [31:0] d, input bit sat);
      bit acc;
      int t;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.sat_en   = sat;
      t = 0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 300);
      if (!acc) chk("push_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t;
      bus.out_ready = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_timeout", q.size(), 0);
      idle(1);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'h0000_7FFF + $urandom_range(0, 2);
         1: return 32'hFFFF_8000 - $urandom_range(0, 2);
         2: return {{16{1'b0}}, 16'($urandom)} ^ {32{$urandom_range(0, 1) == 1}};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.sat_en    = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Basic and overflow cases.
      push(32'h0000_1234, 1);
      push(32'h0001_2345, 1);
      push(32'hFFFE_0000, 1);
      push(32'h0001_2345, 0);
      push(32'hFFFF_8000, 1);
      push(32'h0000_8000, 0);
      drain();
      chk("ovf_cnt_after_basic", ovf_cnt, 4);

      // Backpressure: third push held upstream, first word stays put.
      bus.out_ready = 1'b0;
      push(32'h0000_0011, 0);
      push(32'h0000_0022, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0033;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("held_in_ready", bus.in_ready, 0);
         chk("held_head", bus.out_data, 16'h0011);
      end
      bus.out_ready = 1'b1;
      push(32'h0000_0033, 0);
      drain();

      // Streaming at one word per cycle.
      for (int i = 0; i < 8; i++) push(rand_word(), i[0]);
      drain();

      // Random traffic with random backpressure and occasional clears.
      rand_on = 1;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               push(rand_word(), $urandom_range(0, 1) == 1);
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            rand_on = 0;
         end
         while (rand_on) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
         end
      join
      cnt_clr = 1'b0;
      drain();

      // Mid-stream reset with two words buffered.
      bus.out_ready = 1'b0;
      push(32'h0000_0AAA, 0);
      push(32'h0001_0000, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", bus.out_valid, 0);
      chk("async_rst_in_ready", bus.in_ready, 0);
      idle(2);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      idle(4);

      // Saturation of the overflow counter, then clear against an overflow push.
      for (int i = 0; i < 65534; i++) push(32'h0001_0000, 1);
      idle(1);
      chk("cnt_fffe", ovf_cnt, 16'hFFFE);
      push(32'h8000_0000, 1);
      push(32'h7FFF_FFFF, 0);
      idle(1);
      chk("cnt_sat", ovf_cnt, 16'hFFFF);
      push(32'h0002_0000, 1);
      idle(1);
      chk("cnt_hold", ovf_cnt, 16'hFFFF);
      cnt_clr = 1'b1;
      push(32'h0004_0000, 1);
      cnt_clr = 1'b0;
      idle(1);
      chk("cnt_clr_wins", ovf_cnt, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sign_narrower.md
SIGN_NARROWER -- requirements
Module: sign_narrower

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries in the output buffer (fixed at 2 in this revision).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, in_data and sat_en are valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, the block can accept a word this cycle.
REQ-006 SHALL have port in_data, input, 32, two's-complement word to narrow.
REQ-007 SHALL have port sat_en, input, 1, selects saturate (1) or wrap (0); sampled with in_data.
REQ-008 SHALL have port out_valid, output, 1, out_data and out_ovf are valid.
REQ-009 SHALL have port out_ready, input, 1, the consumer accepts the word this cycle.
REQ-010 SHALL have port out_data, output, 16, the narrowed signed halfword.
REQ-011 SHALL have port out_ovf, output, 1, in_data was not representable in signed 16 bits.
REQ-012 SHALL have port cnt_clr, input, 1, synchronous clear of ovf_cnt.
REQ-013 SHALL have port ovf_cnt, output, 16, saturating count of accepted overflowing words.

Function
REQ-014 SHALL accept a word only in cycles where in_valid and in_ready are both high (push); SHALL release a word only where out_valid and out_ready are both high (pop).
REQ-015 SHALL flag overflow when in_data[31:15] are not all equal.
REQ-016 SHALL produce out_data = in_data[15:0] when there is no overflow, or when there is overflow with sat_en=0 (wrap).
REQ-017 SHALL produce out_data = 16'h7FFF on overflow with sat_en=1 and in_data[31]=0, and 16'h8000 on overflow with sat_en=1 and in_data[31]=1.
REQ-018 SHALL narrow at push time and store {out_data, out_ovf} in a 2-entry FIFO; a word pushed in cycle N SHALL be presented with out_valid=1 in cycle N+1 at the earliest.
REQ-019 SHALL derive in_ready as (occupancy < 2) from registered state only, with no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (occupancy != 0) and present the oldest entry; out_data and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Occupancy rules: push only, +1; pop only, -1; push and pop together at occupancy 1, unchanged and sustaining 1 word/cycle; at occupancy 2 no push is possible.
REQ-022 FIFO read and write pointers SHALL be 1 bit each and wrap from 1 to 0.
REQ-023 SHALL increment ovf_cnt on each push with overflow and hold it at 16'hFFFF once reached (no wrap).
REQ-024 cnt_clr=1 SHALL set ovf_cnt to 0 on the next edge; clear wins over a simultaneous overflow push.
REQ-025 Traffic with in_valid=0 or out_ready=0 SHALL NOT corrupt stored entries.

Reset
REQ-026 While rst_n=0: in_ready=0, out_valid=0, out_data=16'h0000, out_ovf=0, ovf_cnt=16'h0000, occupancy 0, pointers 0.
REQ-027 in_ready SHALL become 1 in the first cycle after rst_n deasserts; entries buffered before a mid-operation reset SHALL be discarded and never presented.

Structure
REQ-028 A shared package SHALL hold W_IN=32, W_OUT=16, SAT_POS=16'h7FFF, SAT_NEG=16'h8000, DEPTH=2 and the 17-bit entry type {data, ovf}.
REQ-029 The FIFO SHALL be the sub-module narrow_fifo2 (push/pop/full/empty, 17-bit entries); narrowing and the counter stay in sign_narrower.

Verification
REQ-030 Push in_data=32'h00001234, sat_en=1, out_ready=1 -> next cycle out_data=16'h1234, out_ovf=0, ovf_cnt=0.
REQ-031 Push 32'h00012345 with sat_en=1 -> out_data=16'h7FFF, out_ovf=1; push 32'hFFFE0000 with sat_en=1 -> 16'h8000; push 32'h00012345 with sat_en=0 -> 16'h2345, out_ovf=1; ovf_cnt=3.
REQ-032 Hold out_ready=0 and push 3 words -> in_ready=0 after 2 pushes, the third is held upstream, and the first word stays stable on out_data; release -> words emerge in order.
REQ-033 Stream 8 words with in_valid=1 and out_ready=1 -> 1 word/cycle, 1-cycle latency, no drops or duplicates.
REQ-034 Preload ovf_cnt=16'hFFFE, push 2 overflowing words -> FFFF and held; cnt_clr together with an overflow push -> 0.
REQ-035 Assert rst_n=0 mid-stream with 2 words buffered -> out_valid=0 immediately; after release, neither word appears.
